// File: rtl/adc_buffer_serializer_pkg.sv
// Shared constants for the ADC capture serializer: channel count, header magic,
// words-per-frame helper and FSM state encoding.
package adc_buffer_serializer_pkg;

    localparam int          ADC_CHANNELS = 4;
    localparam logic [15:0] HEADER_MAGIC = 16'hA5C0;
    localparam int          SEQ_W        = 15;

    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_IDLE   = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    function automatic int words_per_frame(input int channels, input bit header_en);
        return header_en ? channels + 1 : channels;
    endfunction

endpackage

// File: rtl/adc_buffer_serializer_if.sv
// Sample input and Xillybus read-FIFO write side of the ADC serializer.
// The master modport is the serializer; slave is the ADC/FIFO environment.
interface adc_buffer_serializer_if
    import adc_buffer_serializer_pkg::*;
#(
    parameter int adc_channels = ADC_CHANNELS
);
    logic [adc_channels*32-1:0] adc_buffer;
    logic                       adc_valid;
    logic                       adc_wren;
    logic [31:0]                adc_fifo_data;
    logic                       adc_full;

    modport master (
        input  adc_buffer, adc_valid, adc_full,
        output adc_wren, adc_fifo_data
    );

    modport slave (
        output adc_buffer, adc_valid, adc_full,
        input  adc_wren, adc_fifo_data
    );
endinterface

// File: rtl/adc_buffer_serializer_sync_2ff.sv
// Two-flop level synchronizer for slow asynchronous control levels
// (pipe-open flags); shared with the DAC de-interleaver.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    (* ASYNC_REG = "TRUE" *) logic meta;
    (* ASYNC_REG = "TRUE" *) logic sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;
endmodule

// File: rtl/adc_buffer_serializer.sv
// Snapshots one multi-channel ADC sample and writes it channel 0 first into the
// Xillybus read FIFO; whole samples only. ADC_FRAME_HEADER_EN adds a header word.
module adc_buffer_serializer
    import adc_buffer_serializer_pkg::*;
#(
    parameter int adc_channels = ADC_CHANNELS
)(
    input  logic                   capture_clk,
    input  logic                   capture_rst_n,
    input  logic                   adc_fifo_open_bus,
    adc_buffer_serializer_if.master bus,
    output logic                   adc_open,
    output logic                   adc_overrun,
    output logic                   adc_overrun_sticky
);
`ifdef ADC_FRAME_HEADER_EN
    localparam bit HEADER_EN = 1'b1;
`else
    localparam bit HEADER_EN = 1'b0;
`endif
    localparam int WORDS    = words_per_frame(adc_channels, HEADER_EN);
    localparam int IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int FIRST_CH = HEADER_EN ? 1 : 0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t           state;
    logic             fifo_open;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [31:0]      frame_in [WORDS];
    logic [31:0]      snap     [WORDS];
    logic             capture;
    logic             drop;

`ifdef ADC_FRAME_HEADER_EN
    logic [SEQ_W-1:0] seq;
    logic             ovr_pending;
`endif

    sync_2ff u_open_sync (
        .clk   (capture_clk),
        .rst_n (capture_rst_n),
        .d     (adc_fifo_open_bus),
        .q     (fifo_open)
    );

    // NOTE: every frame_in element is assigned on every pass, so no latch is inferred.
    always_comb begin
        for (int c = 0; c < adc_channels; c++) begin
            frame_in[FIRST_CH + c] = bus.adc_buffer[(adc_channels - 1 - c)*32 +: 32];
        end
`ifdef ADC_FRAME_HEADER_EN
        frame_in[0] = {HEADER_MAGIC, ovr_pending, seq};
`endif
    end

    assign capture = (state == ST_IDLE) && fifo_open && bus.adc_valid && !bus.adc_full;
    assign drop    = fifo_open && bus.adc_valid &&
                     (((state == ST_IDLE) && bus.adc_full) || (state == ST_WRITE));
    assign idx_next     = idx + IDX_W'(1);
    assign bus.adc_wren = (state == ST_WRITE) && !bus.adc_full;

    // NOTE: the snapshot is pure data storage qualified by state, so it carries no reset.
    always_ff @(posedge capture_clk) begin
        if (capture) snap <= frame_in;
    end

    // NOTE: non-blocking assignments throughout so every flop samples pre-edge values.
    always_ff @(posedge capture_clk or negedge capture_rst_n) begin
        if (!capture_rst_n) begin
            state              <= ST_CLOSED;
            idx                <= '0;
            adc_open           <= 1'b0;
            adc_overrun        <= 1'b0;
            adc_overrun_sticky <= 1'b0;
            bus.adc_fifo_data  <= '0;
`ifdef ADC_FRAME_HEADER_EN
            seq                <= '0;
            ovr_pending        <= 1'b0;
`endif
        end else begin
            adc_overrun <= drop;
            if (drop) begin
                adc_overrun_sticky <= 1'b1;
`ifdef ADC_FRAME_HEADER_EN
                ovr_pending        <= 1'b1;
`endif
            end
            case (state)
                ST_CLOSED: begin
                    if (fifo_open) begin
                        state    <= ST_IDLE;
                        adc_open <= 1'b1;
                    end
                end
                ST_IDLE, ST_WRITE: begin
                    if (!fifo_open) begin
                        // Closing abandons any partial frame; the host discards it.
                        state              <= ST_CLOSED;
                        adc_open           <= 1'b0;
                        idx                <= '0;
                        adc_overrun_sticky <= 1'b0;
`ifdef ADC_FRAME_HEADER_EN
                        seq                <= '0;
                        ovr_pending        <= 1'b0;
`endif
                    end else if (capture) begin
                        state             <= ST_WRITE;
                        idx               <= '0;
                        bus.adc_fifo_data <= frame_in[0];
`ifdef ADC_FRAME_HEADER_EN
                        seq               <= seq + SEQ_W'(1);
                        ovr_pending       <= 1'b0;
`endif
                    end else if (bus.adc_wren) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_IDLE;
                        end else begin
                            idx               <= idx_next;
                            bus.adc_fifo_data <= snap[idx_next];
                        end
                    end
                end
                default: state <= ST_CLOSED;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_buffer_serializer.sv
// Scoreboard bench for adc_buffer_serializer: a frame-level reference model pushes
// expected FIFO words; a negedge monitor pops and compares every written word.
`timescale 1ns/1ps
module tb_adc_buffer_serializer;
    localparam int CH = 4;
`ifdef ADC_FRAME_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif
    localparam int WORDS = CH + (HDR ? 1 : 0);

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic open_bus = 1'b0;
    logic adc_open;
    logic adc_overrun;
    logic adc_overrun_sticky;

    adc_buffer_serializer_if #(.adc_channels(CH)) bus ();

    adc_buffer_serializer #(.adc_channels(CH)) dut (
        .capture_clk        (clk),
        .capture_rst_n      (rst_n),
        .adc_fifo_open_bus  (open_bus),
        .bus                (bus),
        .adc_open           (adc_open),
        .adc_overrun        (adc_overrun),
        .adc_overrun_sticky (adc_overrun_sticky)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sample is taken only when the pipe is open, no frame is
    // still outstanding and the FIFO has room; otherwise it counts as an overrun.
    logic [31:0] exp_q [$];
    int m_r;
    int m_seq;
    bit m_open, m_ovr, m_sticky, m_pend;
    bit s1, s2;
    bit mon_en = 1'b0;

    always @(posedge clk) begin
        bit fo, busy, written;
        if (!rst_n) begin
            m_r = 0; m_seq = 0; m_open = 0; m_ovr = 0; m_sticky = 0; m_pend = 0;
            s1 = 0; s2 = 0;
            exp_q.delete();
        end else begin
            fo = s2; s2 = s1; s1 = open_bus;
            busy    = (m_r > 0);
            written = busy && !bus.adc_full;
            m_ovr   = 0;
            if (!m_open) begin
                m_open = fo;
            end else if (!fo) begin
                for (int k = 0; k < m_r - int'(written); k++) void'(exp_q.pop_back());
                m_r = 0; m_open = 0; m_sticky = 0; m_pend = 0; m_seq = 0;
            end else begin
                if (written) m_r--;
                if (bus.adc_valid) begin
                    if (busy || bus.adc_full) begin
                        m_ovr = 1; m_sticky = 1; m_pend = 1;
                    end else begin
                        if (HDR) begin
                            exp_q.push_back({16'hA5C0, m_pend, 15'(m_seq)});
                            m_seq  = (m_seq + 1) % 32768;
                            m_pend = 0;
                        end
                        for (int c = 0; c < CH; c++)
                            exp_q.push_back(bus.adc_buffer[(CH - 1 - c)*32 +: 32]);
                        m_r = WORDS;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("adc_wren", 32'(bus.adc_wren), 32'((m_r > 0) && !bus.adc_full));
            if (bus.adc_wren) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: got %h expected no write at %0t",
                             bus.adc_fifo_data, $time);
                end else begin
                    check("adc_fifo_data", bus.adc_fifo_data, exp_q.pop_front());
                end
            end
            check("adc_overrun", 32'(adc_overrun), 32'(m_ovr));
            check("adc_overrun_sticky", 32'(adc_overrun_sticky), 32'(m_sticky));
            check("adc_open", 32'(adc_open), 32'(m_open));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [CH*32-1:0] b);
        bus.adc_buffer = b;
        bus.adc_valid  = 1'b1;
        tick();
        bus.adc_valid  = 1'b0;
    endtask

    function automatic logic [CH*32-1:0] rand_sample();
        logic [CH*32-1:0] b;
        for (int c = 0; c < CH; c++) b[c*32 +: 32] = $urandom();
        return b;
    endfunction

    initial begin
        bus.adc_buffer = '0;
        bus.adc_valid  = 1'b0;
        bus.adc_full   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_open", 32'(adc_open), 32'd0);
        check("reset_overrun", 32'(adc_overrun), 32'd0);
        check("reset_sticky", 32'(adc_overrun_sticky), 32'd0);
        check("reset_data", bus.adc_fifo_data, 32'd0);
        check("reset_wren", 32'(bus.adc_wren), 32'd0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Open latency: adc_open rises on the third edge after the bus level.
        open_bus = 1'b1;
        tick(); check("open_latency_c1", 32'(adc_open), 32'd0);
        tick(); check("open_latency_c2", 32'(adc_open), 32'd0);
        tick(); check("open_latency_c3", 32'(adc_open), 32'd1);

        strobe({32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
        repeat (WORDS + 2) tick();

        // Three-cycle stall in the middle of a frame.
        strobe(rand_sample());
        tick();
        bus.adc_full = 1'b1;
        repeat (3) tick();
        bus.adc_full = 1'b0;
        repeat (WORDS + 2) tick();

        // Second strobe mid-frame is dropped; then close/reopen clears sticky.
        strobe(rand_sample());
        tick();
        strobe(rand_sample());
        repeat (WORDS + 4) tick();
        open_bus = 1'b0;
        repeat (4) tick();
        open_bus = 1'b1;
        repeat (4) tick();

        // Strobe while full in IDLE is dropped; next strobe with room is written.
        bus.adc_full = 1'b1;
        strobe(rand_sample());
        bus.adc_full = 1'b0;
        tick();
        strobe(rand_sample());
        repeat (WORDS + 2) tick();

        // Spacing boundary: one cycle too early is dropped, exact minimum accepted.
        strobe(rand_sample());
        repeat (WORDS - 1) tick();
        strobe(rand_sample());
        repeat (WORDS + 2) tick();
        strobe(rand_sample());
        repeat (WORDS) tick();
        strobe(rand_sample());
        repeat (WORDS + 2) tick();

        // Close mid-frame, then reopen and send a fresh sample.
        strobe(rand_sample());
        tick();
        open_bus = 1'b0;
        repeat (4) tick();
        check("closed_wren", 32'(bus.adc_wren), 32'd0);
        check("closed_open", 32'(adc_open), 32'd0);
        open_bus = 1'b1;
        repeat (4) tick();
        strobe({32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3});
        repeat (WORDS + 2) tick();

        // Header sequence: two frames, a drop, then a third frame.
        strobe(rand_sample());
        repeat (WORDS + 1) tick();
        strobe(rand_sample());
        tick();
        strobe(rand_sample());
        repeat (WORDS + 1) tick();
        strobe(rand_sample());
        repeat (WORDS + 2) tick();

        // Randomized traffic with stalls, overruns and occasional pipe toggles.
        for (int i = 0; i < 1500; i++) begin
            bus.adc_buffer = rand_sample();
            bus.adc_valid  = ($urandom_range(0, 3) == 0);
            bus.adc_full   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 149) == 0) open_bus = ~open_bus;
            tick();
        end
        bus.adc_valid = 1'b0;
        bus.adc_full  = 1'b0;
        open_bus      = 1'b1;
        repeat (30) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/adc_buffer_serializer.md
# adc_buffer_serializer

Interleaves one multi-channel ADC sample into consecutive 32-bit words on the Xillybus read FIFO (FPGA → host). It is the capture-side counterpart of the DAC de-interleaver. A full sample is snapshotted atomically on `adc_valid`, then written channel 0 first, one word per cycle. Only whole samples enter the FIFO: a sample that cannot be accepted is dropped and flagged as overrun, so host-side channel alignment is never lost.

## Interface
Parameters:
- `adc_channels`, default 4: channels per sample; also defined in `adc_params.v`.

Ports:
- `capture_clk`  in  1  acquisition clock; the only clock.
- `capture_rst_n`  in  1  reset, asynchronous assert, active-low.
- `adc_fifo_open_bus`  in  1  Xillybus read-pipe open; asynchronous level, synchronized internally.
- `adc_buffer`  in  adc_channels*32  sample; channel 0 in [adc_channels*32-1 : (adc_channels-1)*32], channel 1 in the next slice down, and so on.
- `adc_valid`  in  1  one-cycle strobe; `adc_buffer` is valid this cycle.
- `adc_open`  out  1  synchronized open; acquisition may start.
- `adc_overrun`  out  1  one-cycle pulse per dropped sample.
- `adc_overrun_sticky`  out  1  set on any overrun; cleared when the pipe closes.
- `adc_wren`  out  1  FIFO write enable; combinational: WRITE state and !`adc_full`.
- `adc_fifo_data`  out  32  FIFO write data, registered.
- `adc_full`  in  1  FIFO full, same-cycle.

## Operation
- Synchronizer: 2 flops with ASYNC_REG on `adc_fifo_open_bus`, giving `fifo_open`. `adc_open` is `fifo_open` registered in IDLE/WRITE.
- States:
  - CLOSED: `adc_open`=0. Clear index, sticky flag and snapshot valid. Go to IDLE when `fifo_open`=1.
  - IDLE: `adc_valid` with `adc_full`=0: capture snapshot, index←0, go to WRITE. `adc_valid` with `adc_full`=1: drop the sample and pulse overrun.
  - WRITE: `adc_fifo_data`=snapshot[index]. When `adc_wren`=1, index advances. After the last word, return to IDLE. When `adc_full`=1, hold the index and data (stall).
- From any state, `fifo_open`=0 goes to CLOSED. A partial sample is abandoned; Xillybus discards it on close.
- `adc_valid` in any WRITE cycle: drop the new sample, pulse overrun, and keep writing the current snapshot. The snapshot is never overwritten mid-frame.
- `adc_valid` in CLOSED is ignored, with no overrun.
- Index width is clog2(words per frame). It does not wrap; the exit to IDLE happens at words−1.

## Timing
- Reset values: `adc_open`=0, `adc_overrun`=0, `adc_overrun_sticky`=0, `adc_fifo_data`=0, state CLOSED; `adc_wren`=0 follows from the state.
- Open latency: 3 cycles from `adc_fifo_open_bus` rising to `adc_open`=1.
- Write latency: `adc_valid` at cycle T gives words at T+1 … T+adc_channels when not stalled.
- Each cycle with `adc_full`=1 in WRITE adds exactly one cycle.
- Without stalls, back-to-back samples need `adc_valid` spacing ≥ adc_channels+1 cycles. A strobe at exactly T+adc_channels+1 is accepted.
- `adc_overrun` is asserted in the cycle after the dropped strobe.

## Configuration
- `ADC_FRAME_HEADER_EN` defined: each frame is preceded by one header word. Words per frame become adc_channels+1.
  - Header [31:16] = 16'hA5C0.
  - Header [15] = an overrun occurred since the previous accepted frame.
  - Header [14:0] = accepted-frame sequence count, wrapping at 2^15, reset in CLOSED.
  - Spacing rule becomes ≥ adc_channels+2 cycles.
- Undefined: no header; frames are adc_channels raw words.

## Structure
- `adc_params.v` holds the shared constants:
  - `adc_channels`
  - header magic
  - words-per-frame
  - state encodings
- Sub-module `sync_2ff` for the open synchronizer. The DAC side can reuse it.

## Test plan
- Open, then `adc_valid` with ch0..ch3 = 0x11111111..0x44444444 → 4 `adc_wren` cycles with data in that order, at T+1..T+4.
- `adc_full` high for 3 cycles during word 2 → word 2 held; the frame completes at T+7 with no overrun.
- `adc_valid` at T and T+2 → second sample dropped, `adc_overrun` pulses once, sticky=1, first frame intact. Then close/reopen → sticky=0.
- `adc_valid` while `adc_full`=1 in IDLE → no writes, one overrun pulse. The next strobe with room writes normally.
- Deassert `adc_fifo_open_bus` mid-frame → `adc_wren`=0 within 3 cycles, `adc_open`=0. Reopen and send a sample → ch0 written first.
- `ADC_FRAME_HEADER_EN` defined: three frames give headers 0xA5C00000, 0xA5C00001, 0xA5C00002. A drop before frame 3 gives 0xA5C08002.
